// File: rtl/matrix_result_printer.sv
// ============================================================================
// matrix_result_printer
// Prints an up-to-5x5 matrix of 16-bit unsigned values as ASCII decimal text,
// one CR LF terminated line per row, over a valid/ready byte stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_result_printer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [399:0] matrix_flat,
  input  logic [2:0]   m,
  input  logic [2:0]   n,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONVERT  = 3'd1,
    S_EMIT_DIG = 3'd2,
    S_EMIT_SP  = 3'd3,
    S_EMIT_CR  = 3'd4,
    S_EMIT_LF  = 3'd5,
    S_FINISH   = 3'd6
  } state_t;

  state_t         r_state,    w_state_nxt;
  logic [399:0]   r_mat,      w_mat_nxt;
  logic [2:0]     r_m,        w_m_nxt;
  logic [2:0]     r_n,        w_n_nxt;
  logic [2:0]     r_row,      w_row_nxt;
  logic [2:0]     r_col,      w_col_nxt;
  logic [3:0]     r_bitcnt,   w_bitcnt_nxt;
  logic [15:0]    r_shift,    w_shift_nxt;
  logic [19:0]    r_bcd,      w_bcd_nxt;
  logic [2:0]     r_dig,      w_dig_nxt;
  logic [7:0]     r_tx_data,  w_tx_data_nxt;
  logic           r_tx_valid, w_tx_valid_nxt;
  logic           r_busy,     w_busy_nxt;
  logic           r_done,     w_done_nxt;
  logic           r_err,      w_err_nxt;

  logic [19:0]    w_adj;
  logic [19:0]    w_bcd_step;
  logic [2:0]     w_lead;
  logic [7:0]     w_lead_char;
  logic [2:0]     w_dig_sel;
  logic [7:0]     w_dig_char;
  logic [2:0]     w_ld_row;
  logic [2:0]     w_ld_col;
  logic [4:0]     w_idx;
  logic [15:0]    w_ld_val;
  logic           w_fire;
  logic           w_dims_bad;

  // One double-dabble step: add 3 to every digit >= 5, then shift in next bit.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
    w_bcd_step = (w_adj << 1) | {19'd0, r_shift[15]};
  end

  always_comb begin
    w_lead = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (w_bcd_step[i*4 +: 4] != 4'd0) w_lead = 3'(i);
    end
    w_lead_char = 8'h30 + {4'h0, w_bcd_step[{w_lead, 2'b00} +: 4]};
    w_dig_sel   = r_dig - 3'd1;
    w_dig_char  = 8'h30 + {4'h0, r_bcd[{w_dig_sel, 2'b00} +: 4]};
  end

  // Element fetched when (re)entering CONVERT from a separator state.
  always_comb begin
    w_ld_row = (r_state == S_EMIT_LF) ? r_row + 3'd1 : r_row;
    w_ld_col = (r_state == S_EMIT_SP) ? r_col + 3'd1 : 3'd0;
    w_idx    = {2'b00, w_ld_row} * {2'b00, r_n} + {2'b00, w_ld_col};
    w_ld_val = r_mat[{w_idx, 4'b0000} +: 16];
  end

  assign w_fire     = r_tx_valid & tx_ready;
  assign w_dims_bad = (m == 3'd0) || (m > 3'd5) || (n == 3'd0) || (n > 3'd5);

  always_comb begin
    w_state_nxt    = r_state;
    w_mat_nxt      = r_mat;
    w_m_nxt        = r_m;
    w_n_nxt        = r_n;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_bcd_nxt      = r_bcd;
    w_dig_nxt      = r_dig;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mat_nxt    = matrix_flat;
          w_m_nxt      = m;
          w_n_nxt      = n;
          w_row_nxt    = 3'd0;
          w_col_nxt    = 3'd0;
          w_bitcnt_nxt = 4'd0;
          w_bcd_nxt    = 20'd0;
          w_shift_nxt  = matrix_flat[15:0];
          if (w_dims_bad) begin
            w_state_nxt = S_FINISH;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_CONVERT;
            w_busy_nxt  = 1'b1;
          end
        end
      end

      S_CONVERT: begin
        w_shift_nxt  = {r_shift[14:0], 1'b0};
        w_bcd_nxt    = w_bcd_step;
        w_bitcnt_nxt = r_bitcnt + 4'd1;
        if (r_bitcnt == 4'd15) begin
          w_state_nxt    = S_EMIT_DIG;
          w_dig_nxt      = w_lead;
          w_tx_data_nxt  = w_lead_char;
          w_tx_valid_nxt = 1'b1;
        end
      end

      S_EMIT_DIG: begin
        if (w_fire) begin
          if (r_dig == 3'd0) begin
            if (r_col < r_n - 3'd1) begin
              w_state_nxt   = S_EMIT_SP;
              w_tx_data_nxt = 8'h20;
            end else begin
              w_state_nxt   = S_EMIT_CR;
              w_tx_data_nxt = 8'h0D;
            end
          end else begin
            w_dig_nxt     = w_dig_sel;
            w_tx_data_nxt = w_dig_char;
          end
        end
      end

      S_EMIT_SP: begin
        if (w_fire) begin
          w_state_nxt    = S_CONVERT;
          w_col_nxt      = w_ld_col;
          w_shift_nxt    = w_ld_val;
          w_bcd_nxt      = 20'd0;
          w_bitcnt_nxt   = 4'd0;
          w_tx_valid_nxt = 1'b0;
        end
      end

      S_EMIT_CR: begin
        if (w_fire) begin
          w_state_nxt   = S_EMIT_LF;
          w_tx_data_nxt = 8'h0A;
        end
      end

      S_EMIT_LF: begin
        if (w_fire) begin
          w_col_nxt      = 3'd0;
          w_tx_valid_nxt = 1'b0;
          if (r_row < r_m - 3'd1) begin
            w_state_nxt  = S_CONVERT;
            w_row_nxt    = w_ld_row;
            w_shift_nxt  = w_ld_val;
            w_bcd_nxt    = 20'd0;
            w_bitcnt_nxt = 4'd0;
          end else begin
            w_state_nxt = S_FINISH;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end

      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_tx_valid_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mat      <= '0;
      r_m        <= 3'd0;
      r_n        <= 3'd0;
      r_row      <= 3'd0;
      r_col      <= 3'd0;
      r_bitcnt   <= 4'd0;
      r_shift    <= 16'd0;
      r_bcd      <= 20'd0;
      r_dig      <= 3'd0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mat      <= w_mat_nxt;
      r_m        <= w_m_nxt;
      r_n        <= w_n_nxt;
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_bcd      <= w_bcd_nxt;
      r_dig      <= w_dig_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_matrix_result_printer.sv
// ============================================================================
// tb_matrix_result_printer
// Randomized self-checking bench: expected text built with $sformatf.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matrix_result_printer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [399:0] matrix_flat = '0;
  logic [2:0]   m = 3'd0;
  logic [2:0]   n = 3'd0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         busy;
  logic         done;
  logic         err;

  matrix_result_printer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_flat (matrix_flat),
    .m           (m),
    .n           (n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc_abs = 0;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  bit rdy_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         xfer_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       done_err = 1'b0;
  int         first_valid = -1;
  int         busy_cnt = 0;
  int         s_cyc = 0;
  logic [7:0] prev_data = 8'd0;
  bit         prev_stall = 1'b0;
  logic [15:0] tm[25];

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Reference text: each value in decimal, single spaces between, CR LF per row.
  task automatic build_exp(input int mm, input int nn);
    string s;
    exp_q.delete();
    for (int r = 0; r < mm; r++) begin
      for (int c = 0; c < nn; c++) begin
        s = $sformatf("%0d", tm[r*nn + c]);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
        if (c < nn - 1) exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic monitor();
    int cr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cr = cyc_abs - s_cyc + 1;
        if (prev_stall) begin
          chk("hold_valid", int'(tx_valid), 1);
          chk("hold_data", int'(tx_data), int'(prev_data));
        end
        if (tx_valid && first_valid < 0) first_valid = cr;
        if (busy) busy_cnt++;
        if (tx_valid && tx_ready) begin
          xfer_cyc.push_back(cr);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_byte: got %0d, expected no byte", tx_data);
          end else begin
            chk("byte", int'(tx_data), int'(exp_q[0]));
            void'(exp_q.pop_front());
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cr;
          done_err = err;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  endtask

  task automatic launch(input int mm, input int nn, input bit valid_dims);
    if (valid_dims) build_exp(mm, nn);
    else exp_q.delete();
    xfer_cyc.delete();
    first_valid = -1;
    busy_cnt = 0;
    @(negedge clk);
    matrix_flat = '0;
    for (int i = 0; i < 25; i++) begin
      if (i < mm*nn) matrix_flat[i*16 +: 16] = tm[i];
    end
    m = 3'(mm);
    n = 3'(nn);
    start = 1'b1;
    @(posedge clk);
    #1;
    s_cyc = cyc_abs;
    start = 1'b0;
  endtask

  task automatic run_print(input int mm, input int nn, input bit rnd, input bit poke,
                           input bit bad);
    int base_done;
    int t;
    base_done = done_cnt;
    rdy_rand = rnd;
    launch(mm, nn, !bad);
    if (bad) begin
      @(negedge clk);
      chk("bad_done_c1", int'(done), 1);
      chk("bad_err_c1", int'(err), 1);
      chk("bad_busy_c1", int'(busy), 0);
      @(negedge clk);
      chk("bad_done_c2", int'(done), 0);
      chk("bad_busy_c2", int'(busy), 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 25; i++) matrix_flat[i*16 +: 16] = 16'($urandom);
    m = 3'($urandom);
    n = 3'($urandom);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      m = 3'd1;
      n = 3'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == base_done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", int'(t < 5000), 1);
    repeat (3) @(negedge clk);
    chk("bytes_left", exp_q.size(), 0);
    chk("done_pulses", done_cnt - base_done, 1);
    chk("done_err", int'(done_err), int'(bad));
    chk("idle_busy", int'(busy), 0);
    rdy_rand = 1'b0;
  endtask

  initial begin
    string lit;
    int mm;
    int nn;
    int t;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pin the reference model against hand-written text.
    tm[0] = 16'd1; tm[1] = 16'd23; tm[2] = 16'd456; tm[3] = 16'd7890;
    build_exp(2, 2);
    lit = "1 23\r\n456 7890\r\n";
    chk("model_len", exp_q.size(), lit.len());
    for (int k = 0; k < 16; k++) chk("model_char", int'(exp_q[k]), int'(lit[k]));

    run_print(2, 2, 1'b0, 1'b0, 1'b0);
    chk("2x2_nbytes", xfer_cyc.size(), 16);

    tm[0] = 16'd0;
    run_print(1, 1, 1'b0, 1'b0, 1'b0);
    chk("1x1_nbytes", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      chk("1x1_cyc_0", xfer_cyc[0], 17);
      chk("1x1_cyc_cr", xfer_cyc[1], 18);
      chk("1x1_cyc_lf", xfer_cyc[2], 19);
    end
    chk("1x1_first_valid", first_valid, 17);
    chk("1x1_done_cyc", done_cyc, 20);
    chk("1x1_busy_cycles", busy_cnt, 19);

    tm[0] = 16'd65535; tm[1] = 16'd10; tm[2] = 16'd100;
    run_print(1, 3, 1'b0, 1'b1, 1'b0);
    chk("1x3_nbytes", xfer_cyc.size(), 14);

    for (int i = 0; i < 6; i++) tm[i] = 16'($urandom);
    run_print(3, 2, 1'b0, 1'b0, 1'b0);
    run_print(3, 2, 1'b1, 1'b0, 1'b0);

    run_print(0, 3, 1'b0, 1'b0, 1'b1);
    chk("m0_no_valid", first_valid, -1);
    chk("m0_done_cyc", done_cyc, 1);
    run_print(2, 6, 1'b0, 1'b0, 1'b1);
    chk("n6_no_valid", first_valid, -1);
    chk("n6_done_cyc", done_cyc, 1);

    for (int it = 0; it < 4; it++) begin
      mm = $urandom_range(1, 5);
      nn = $urandom_range(1, 5);
      for (int i = 0; i < 25; i++) tm[i] = 16'($urandom >> $urandom_range(0, 16));
      run_print(mm, nn, 1'b1, 1'b0, 1'b0);
    end
    tm[0] = 16'd0; tm[1] = 16'd40000;
    run_print(1, 2, 1'b1, 1'b0, 1'b0);

    // Abort mid-stream with reset during the second byte.
    tm[0] = 16'd1; tm[1] = 16'd23; tm[2] = 16'd456; tm[3] = 16'd7890;
    launch(2, 2, 1'b1);
    t = 0;
    while (xfer_cyc.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_first_byte", int'(t < 200), 1);
    @(posedge clk);
    #2;
    chk("abort_valid_before", int'(tx_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx_valid", int'(tx_valid), 0);
    chk("abort_tx_data", int'(tx_data), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tm[0] = 16'd5; tm[1] = 16'd6;
    run_print(1, 2, 1'b0, 1'b0, 1'b0);
    chk("after_rst_nbytes", xfer_cyc.size(), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_result_printer.md
# matrix_result_printer

Serializes a matrix result (up to 5x5, 16-bit unsigned elements, compact row-major) into an ASCII decimal byte stream for the UART transmit path. It sits downstream of the matrix ALU and consumes its `result_flat` / `result_m` / `result_n` / `done` outputs. It emits one text line per row on a valid/ready byte interface.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request print; sampled only in IDLE.
- `matrix_flat`  in  400  element (r,c) at `[(r*n+c)*16 +: 16]`; latched on accepted start.
- `m`  in  3  row count; latched on accepted start.
- `n`  in  3  column count; latched on accepted start.
- `tx_data`  out  8  ASCII byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte; transfer occurs when `tx_valid && tx_ready` at a rising edge.
- `busy`  out  1  print in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: dimensions were invalid.

## Operation
- Reset values: `tx_data` = 0, `tx_valid` = 0, `busy` = 0, `done` = 0, `err` = 0. State is IDLE and all counters are 0.
- States: IDLE, CONVERT, EMIT_DIG, EMIT_SP, EMIT_CR, EMIT_LF, FINISH.
- IDLE, start high:
  - Latch `matrix_flat`, `m` and `n`. Set r = c = 0 and `busy` = 1.
  - If m or n is outside 1..5, go to FINISH with `err` = 1.
  - Otherwise go to CONVERT.
- `start` outside IDLE is ignored.
- CONVERT: sequential double-dabble on element (r,c), one bit per cycle. It takes exactly 16 cycles and yields 5 BCD digits, then goes to EMIT_DIG.
- EMIT_DIG:
  - Leading zeros are suppressed. The value 0 prints as a single `'0'`.
  - Each digit is `8'h30 + bcd`, most significant first.
  - After the last digit is transferred: if c < n-1, go to EMIT_SP; otherwise go to EMIT_CR.
- EMIT_SP: sends `8'h20`, then c += 1 and go to CONVERT.
- EMIT_CR: sends `8'h0D`, then go to EMIT_LF.
- EMIT_LF: sends `8'h0A`, then c = 0. If r < m-1, r += 1 and go to CONVERT; otherwise go to FINISH.
- There is no trailing space on any row. Every row, including the last, ends with CR LF.
- FINISH:
  - `done` = 1 for one cycle and `busy` = 0 in that same cycle.
  - `err` is held for that cycle only: 1 for invalid dimensions, 0 otherwise.
  - Then go to IDLE.
- Element values are printed unsigned over the full 0..65535 range. No saturation is applied.

## Timing
- `tx_valid` is a registered output and is high exactly in the EMIT_* states.
- `tx_data` must not change while `tx_valid && !tx_ready`.
- On a transfer edge the next state's byte, if any, is presented in the following cycle. Bytes within a number and its trailing SP/CR/LF therefore go back-to-back when `tx_ready` stays high.
- Accepted start at edge 0: `busy` = 1 from cycle 1, CONVERT occupies cycles 1-16, and the first `tx_valid` is in cycle 17.
- Each later element adds 16 CONVERT cycles with `tx_valid` low, then its digits.
- With `tx_ready` held high, a 1x1 matrix holding 0 gives: `'0'` in cycle 17, CR in 18, LF in 19, and `done` in 20.
- Invalid dimensions: FINISH is in cycle 1, so `done` = `err` = 1 in cycle 1, with no `tx_valid` ever asserted.
- `rst_n` low at any point, including mid-byte with `tx_valid` high: every output goes to its reset value immediately. The partial stream is abandoned, and the next start prints the complete matrix.
- `matrix_flat`, `m` and `n` may change after the start edge without affecting output.

## Test plan
- 2x2 [1, 23; 456, 7890], `tx_ready` = 1 -> exactly the 16 bytes "1 23\r\n456 7890\r\n", one `done` pulse, `err` = 0.
- 1x1 [0], `tx_ready` = 1 -> bytes 30 0D 0A in cycles 17, 18, 19; `done` in cycle 20; `busy` high in cycles 1-19.
- 1x3 [65535, 10, 100] -> "65535 10 100\r\n"; also change the inputs at cycle 2 and check the printed values are the originally latched ones.
- 3x2 random 16-bit values with `tx_ready` toggled pseudo-randomly -> byte sequence identical to the `tx_ready` = 1 run; `tx_data` stable whenever valid without ready.
- m = 0, then n = 6 -> no `tx_valid`; `done` = `err` = 1 in cycle 1; back in IDLE in cycle 2.
- Start pulsed while busy is ignored. Assert `rst_n` low during the second byte -> `tx_valid` goes low at once; after reset, a new start on 1x2 [5, 6] gives "5 6\r\n".
